// File: rtl/sequenciador_acordes_if.sv
// sequenciador_acordes_if: bus between the chord sequencer and the chord identifier
//   id_reset  active-high reset into the identifier
//   id_ok     note-accept pulse
//   id_nota   note presented with id_ok
//   id_fim    identifier finished
//   id_tipo   identified chord type
interface sequenciador_acordes_if;
  logic       id_reset;
  logic       id_ok;
  logic [3:0] id_nota;
  logic       id_fim;
  logic [1:0] id_tipo;
  modport master (output id_reset, id_ok, id_nota, input id_fim, id_tipo);
  modport slave (input id_reset, id_ok, id_nota, output id_fim, id_tipo);
endinterface

// File: rtl/sequenciador_acordes.sv
// sequenciador_acordes: buffers up to MAX_NOTAS notes and feeds them, null-padded, to the chord identifier
//   clk, reset (async, active low)
//   nota_in/grava/limpar/iniciar  note-entry front end
//   contagem/ocupado/pronto/resultado/erro_timeout  status and captured chord type
//   id  identifier bus (master side)
module sequenciador_acordes #(
  parameter int MAX_NOTAS = 4,
  parameter int GAP       = 2,
  parameter int TIMEOUT   = 16,
  parameter int CLR_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              nota_in,
  input  logic                    grava,
  input  logic                    limpar,
  input  logic                    iniciar,
  output logic [2:0]              contagem,
  output logic                    ocupado,
  output logic                    pronto,
  output logic [1:0]              resultado,
  output logic                    erro_timeout,
  sequenciador_acordes_if.master  id
);
  typedef enum logic [2:0] {OCIOSO, LIMPA, APRESENTA, PULSO, ESPERA, AGUARDA, CONCLUI} estado_t;
  estado_t    estado;
  logic [3:0] notas [MAX_NOTAS];
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [3:0] nota_sel;
  // note for the next pulse: buffered note while idx < contagem, null pad afterwards
  always_comb begin
    nota_sel = '0;
    for (int i = 0; i < MAX_NOTAS; i++)
      if (3'(i) == idx && idx < contagem) nota_sel = notas[i];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      estado       <= OCIOSO;
      contagem     <= '0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
      resultado    <= '0;
      erro_timeout <= 1'b0;
      idx          <= '0;
      cnt          <= '0;
      id.id_reset  <= 1'b1;
      id.id_ok     <= 1'b0;
      id.id_nota   <= '0;
      for (int i = 0; i < MAX_NOTAS; i++) notas[i] <= '0;
    end else begin
      case (estado)
        OCIOSO: begin
          id.id_reset <= 1'b0;
          id.id_ok    <= 1'b0;
          if (limpar) contagem <= '0;
          else if (grava && contagem < 3'(MAX_NOTAS)) begin
            for (int i = 0; i < MAX_NOTAS; i++)
              if (3'(i) == contagem) notas[i] <= nota_in;
            contagem <= contagem + 3'd1;
          end
          // the note stored in this same cycle is already part of the run
          if (iniciar) begin
            pronto       <= 1'b0;
            erro_timeout <= 1'b0;
            resultado    <= '0;
            ocupado      <= 1'b1;
            idx          <= '0;
            cnt          <= '0;
            id.id_reset  <= 1'b1;
            estado       <= LIMPA;
          end
        end
        LIMPA:
          if (cnt == 8'(CLR_CYC - 1)) begin
            id.id_reset <= 1'b0;
            id.id_nota  <= nota_sel;
            estado      <= APRESENTA;
          end else cnt <= cnt + 8'd1;
        APRESENTA: begin
          id.id_ok <= 1'b1;
          estado   <= PULSO;
        end
        PULSO: begin
          id.id_ok <= 1'b0;
          idx      <= idx + 3'd1;
          cnt      <= '0;
          estado   <= ESPERA;
        end
        ESPERA:
          if (cnt == 8'(GAP - 1)) begin
            cnt <= '0;
            if (id.id_fim) begin
              resultado <= id.id_tipo;
              estado    <= CONCLUI;
            end else if (idx < 3'(MAX_NOTAS + 1)) begin
              id.id_nota <= nota_sel;
              estado     <= APRESENTA;
            end else estado <= AGUARDA;
          end else cnt <= cnt + 8'd1;
        AGUARDA:
          if (id.id_fim) begin
            resultado <= id.id_tipo;
            estado    <= CONCLUI;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            erro_timeout <= 1'b1;
            resultado    <= '0;
            estado       <= CONCLUI;
          end else cnt <= cnt + 8'd1;
        CONCLUI: begin
          pronto   <= 1'b1;
          ocupado  <= 1'b0;
          contagem <= '0;
          estado   <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
endmodule

// File: tb/tb_sequenciador_acordes.sv
// tb_sequenciador_acordes: randomized runs against a queue-based model and a mock chord identifier
module tb_sequenciador_acordes;
  localparam int MAXN = 4, GAP = 2, TMO = 16;
  logic       clk = 0, reset = 0;
  logic [3:0] nota_in = 0;
  logic       grava = 0, limpar = 0, iniciar = 0;
  logic [2:0] contagem;
  logic       ocupado, pronto, erro_timeout;
  logic [1:0] resultado;
  sequenciador_acordes_if bus();
  sequenciador_acordes dut (
    .clk(clk), .reset(reset), .nota_in(nota_in), .grava(grava), .limpar(limpar),
    .iniciar(iniciar), .contagem(contagem), .ocupado(ocupado), .pronto(pronto),
    .resultado(resultado), .erro_timeout(erro_timeout), .id(bus)
  );
  always #5 clk = ~clk;
  int nchk = 0, npass = 0;
  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask
  // mock identifier: raises fim fim_d cycles after seeing pulse number fim_k (0 = never)
  int fim_k = 0, fim_d = 0, npul = 0, left = 0;
  logic [1:0] tipo_run = 0;
  assign bus.id_tipo = tipo_run;
  always @(posedge clk) begin
    if (bus.id_reset) begin
      npul <= 0;
      left <= 0;
      bus.id_fim <= 1'b0;
    end else begin
      if (bus.id_ok) begin
        npul <= npul + 1;
        if (npul + 1 == fim_k) begin
          if (fim_d == 0) bus.id_fim <= 1'b1;
          else left <= fim_d;
        end
      end
      if (left > 0) begin
        left <= left - 1;
        if (left == 1) bus.id_fim <= 1'b1;
      end
    end
  end
  logic [3:0] seen[$];
  logic       ok_q = 0;
  logic [3:0] nota_q = 0;
  always @(negedge clk) begin
    if (bus.id_ok && !ok_q) begin
      seen.push_back(bus.id_nota);
      chk("nota_setup", bus.id_nota, nota_q);
      chk("id_reset_at_ok", bus.id_reset, 0);
    end
    ok_q   <= bus.id_ok;
    nota_q <= bus.id_nota;
  end
  logic [3:0] model[$];
  task automatic do_grava(input logic [3:0] n);
    @(negedge clk);
    nota_in = n;
    grava = 1;
    @(negedge clk);
    grava = 0;
    if (model.size() < MAXN) model.push_back(n);
  endtask
  task automatic do_limpar(input bit gv, input logic [3:0] n);
    @(negedge clk);
    limpar = 1;
    grava = gv;
    nota_in = n;
    @(negedge clk);
    limpar = 0;
    grava = 0;
    model.delete();
  endtask
  task automatic run(input int k, input int d, input logic [1:0] t, input bit noisy,
                     input bit gv, input logic [3:0] gn);
    int p, n, lat;
    bit to;
    fim_k = k;
    fim_d = d;
    tipo_run = t;
    to = (k == 0) || (k == MAXN + 1 && d >= GAP + TMO);
    p = to ? MAXN + 1 : k;
    lat = to ? 4 * (MAXN + 1) + 4 + TMO : (d < GAP) ? 4 * p + 4 : 4 * p + 4 + d - GAP + 1;
    @(negedge clk);
    seen.delete();
    iniciar = 1;
    grava = gv;
    nota_in = gn;
    if (gv && model.size() < MAXN) model.push_back(gn);
    @(posedge clk);
    #1;
    iniciar = 0;
    grava = 0;
    n = 1;
    chk("ocupado_run", ocupado, 1);
    chk("pronto_cleared", pronto, 0);
    while (!pronto && n < 200) begin
      if (noisy) begin
        grava = 1'($urandom);
        limpar = 1'($urandom);
        iniciar = 1'($urandom);
        nota_in = 4'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
    end
    grava = 0;
    limpar = 0;
    iniciar = 0;
    chk("latency", n, lat);
    chk("pronto", pronto, 1);
    chk("resultado", resultado, to ? 0 : int'(t));
    chk("erro_timeout", erro_timeout, int'(to));
    chk("contagem_after", contagem, 0);
    chk("ocupado_after", ocupado, 0);
    chk("pulses", seen.size(), p);
    for (int i = 0; i < p && i < seen.size(); i++)
      chk("id_nota", seen[i], i < model.size() ? int'(model[i]) : 0);
    repeat (3) @(negedge clk);
    chk("pronto_hold", pronto, 1);
    chk("resultado_hold", resultado, to ? 0 : int'(t));
    model.delete();
  endtask
  initial begin
    int k, d, ng;
    bit found;
    repeat (3) @(negedge clk);
    chk("rst_contagem", contagem, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_resultado", resultado, 0);
    chk("rst_erro", erro_timeout, 0);
    chk("rst_id_ok", bus.id_ok, 0);
    chk("rst_id_nota", bus.id_nota, 0);
    chk("rst_id_reset", bus.id_reset, 1);
    reset = 1;
    @(negedge clk);
    chk("idle_id_reset", bus.id_reset, 0);
    do_grava(4'b0001); do_grava(4'b0011); do_grava(4'b1110);
    chk("contagem3", contagem, 3);
    run(4, 0, 2'b01, 0, 0, 0);
    do_grava(4'b0001); do_grava(4'b0011); do_grava(4'b1110); do_grava(4'b0001);
    run(5, 0, 2'b10, 0, 0, 0);
    do_grava(4'b0001); do_grava(4'b0011); do_grava(4'b1111); do_grava(4'b1010);
    run(5, 1, 2'b10, 0, 0, 0);
    do_grava(4'b0001); do_grava(4'b0011); do_grava(4'b1110); do_grava(4'b1111);
    run(5, 0, 2'b11, 0, 0, 0);
    run(1, 0, 2'b00, 0, 0, 0);
    do_grava(4'b0001); do_grava(4'b0011); do_grava(4'b0001);
    run(3, 1, 2'b00, 0, 0, 0);
    for (int i = 0; i < 6; i++) do_grava(4'(i + 2));
    chk("contagem_full", contagem, MAXN);
    run(5, 0, 2'b01, 0, 0, 0);
    run(0, 0, 2'b11, 0, 0, 0);
    run(5, 17, 2'b10, 0, 0, 0);
    run(5, 18, 2'b10, 0, 0, 0);
    do_grava(4'b0101);
    do_limpar(1, 4'b0110);
    chk("limpar_priority", contagem, 0);
    for (int it = 0; it < 30; it++) begin
      ng = $urandom_range(0, 6);
      for (int j = 0; j < ng; j++) begin
        if ($urandom_range(0, 7) == 0) do_limpar(1'($urandom), 4'($urandom));
        else do_grava(4'($urandom));
      end
      chk("contagem_rand", contagem, model.size());
      k = $urandom_range(0, 5);
      d = (k == MAXN + 1) ? $urandom_range(0, 20) : $urandom_range(0, 1);
      run(k, d, 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    end
    fim_k = 0;
    do_grava(4'b0010); do_grava(4'b0100);
    @(negedge clk);
    iniciar = 1;
    @(negedge clk);
    iniciar = 0;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.id_ok) found = 1;
      else @(negedge clk);
    end
    chk("pulso_reached", found, 1);
    reset = 0;
    #1;
    chk("abort_id_ok", bus.id_ok, 0);
    chk("abort_id_reset", bus.id_reset, 1);
    chk("abort_ocupado", ocupado, 0);
    chk("abort_contagem", contagem, 0);
    model.delete();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    run(1, 0, 2'b11, 0, 1, 4'b0110);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/sequenciador_acordes.md
Name: sequenciador_acordes

Overview:
- Controller that buffers up to four notes typed by the user, then drives the chord identifier with one note per `ok` pulse.
- It resets the identifier first, pads the sequence with the null note until the identifier reports `fim`, captures `tipo`, and presents the result with a done flag.
- Sits between the note-entry front end and the chord identifier; it is the only agent driving the identifier's `reset`, `ok` and `nota` inputs.

Parameters:
MAX_NOTAS, 4, buffer depth in notes; maximum `ok` pulses per run = MAX_NOTAS+1.
GAP, 2, idle clk cycles after each `id_ok` pulse before sampling `id_fim`; legal minimum 2.
TIMEOUT, 16, clk cycles to wait for `id_fim` after the last pulse before flagging an error.
CLR_CYC, 2, clk cycles `id_reset` is held during the clear phase.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
nota_in  in  4  note code to store (identifier encoding; 0000/1000 = null)
grava  in  1  write strobe; stores nota_in into the buffer
limpar  in  1  clears the buffer (count to 0), OCIOSO only
iniciar  in  1  start-run strobe
contagem  out  3  notes currently buffered (0..MAX_NOTAS)
ocupado  out  1  high from accepted iniciar until CONCLUI
pronto  out  1  result valid
resultado  out  2  captured tipo (00 nenhum/erro, 01 adj, 10 comp, 11 adv)
erro_timeout  out  1  identifier never raised fim
id_reset  out  1  active-high reset to the identifier
id_ok  out  1  note-accept pulse to the identifier
id_nota  out  4  note presented to the identifier
id_fim  in  1  identifier processed flag
id_tipo  in  2  identifier chord type

Behaviour:
- All outputs registered. Reset values:
  - contagem=0, ocupado=0, pronto=0, resultado=00, erro_timeout=0.
  - id_ok=0, id_nota=0000, id_reset=1.
  - FSM=OCIOSO.
- While reset is low, id_reset stays 1, so the identifier is held in reset too.
- Reset asserted mid-run aborts immediately to these values; the buffer is lost.
- FSM states: OCIOSO, LIMPA, APRESENTA, PULSO, ESPERA, AGUARDA, CONCLUI.
- OCIOSO: id_reset=0, id_ok=0.
  - grava with contagem<MAX_NOTAS: buf[contagem]<=nota_in, contagem++.
  - grava when full: ignored, contagem unchanged.
  - limpar: contagem<=0; limpar has priority over grava in the same cycle.
  - iniciar: pronto<=0, erro_timeout<=0, resultado<=00, ocupado<=1, idx<=0, go to LIMPA.
  - grava+iniciar in the same cycle: the note is stored and is included in the run.
- LIMPA: id_reset=1 for CLR_CYC cycles, then id_reset=0 and go to APRESENTA.
- APRESENTA (1 cycle): id_nota<=buf[idx] if idx<contagem, else 0000 (pad); id_ok=0.
- PULSO (1 cycle): id_ok=1; id_nota held; idx++.
- ESPERA (GAP cycles): id_ok=0; id_nota held. On the final cycle, sample id_fim:
  - id_fim=1: resultado<=id_tipo, go to CONCLUI.
  - else if idx<MAX_NOTAS+1: go to APRESENTA.
  - else: timer<=0, go to AGUARDA.
- AGUARDA: count up to TIMEOUT.
  - id_fim=1 at any cycle: resultado<=id_tipo, go to CONCLUI.
  - Timer reaches TIMEOUT: erro_timeout<=1, resultado<=00, go to CONCLUI.
- CONCLUI (1 cycle): pronto<=1, ocupado<=0, contagem<=0 (buffer consumed), go to OCIOSO.
  - pronto, resultado and erro_timeout hold until the next accepted iniciar or reset.
- Strobes outside OCIOSO (grava, limpar, iniciar) are ignored.
- Per-pulse cost: 1 (APRESENTA) + 1 (PULSO) + GAP cycles.
- id_nota is stable at least one clk before the id_ok rising edge and through GAP cycles after it.
- The run never issues more than MAX_NOTAS+1 id_ok pulses.
- Latency, defaults, run ending on pulse k, iniciar to pronto: 1 (iniciar registered) + CLR_CYC + 4k + 1 (CONCLUI) = 4k+4 cycles.
- idx is 3 bits and never wraps.

Test Plan:
1. grava 0001, 0011, 1110; iniciar -> exactly 4 id_ok pulses (last id_nota=0000), pronto=1, resultado=01, erro_timeout=0, contagem=0.
2. grava 0001, 0011, 1110, 0001; iniciar -> 5 pulses (5th id_nota=0000), resultado=10. Same with 1111, 1010 as notes 3-4 -> resultado=10.
3. grava 0001, 0011, 1110, 1111; iniciar -> resultado=11. Empty buffer iniciar -> 1 pulse with id_nota=0000, resultado=00, pronto=1.
4. grava 0001, 0011, 0001; iniciar -> fim after 3rd pulse, only 3 id_ok pulses, resultado=00. grava 6 times in OCIOSO -> contagem=4, first 4 notes kept.
5. Identifier model with id_fim stuck 0 -> 5 pulses, then TIMEOUT=16 cycles, then erro_timeout=1, resultado=00, pronto=1.
6. reset low during PULSO -> same edge: id_ok=0, id_reset=1, ocupado=0, contagem=0. After release: grava+iniciar same cycle -> stored note sent as first id_nota.
